// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue
//   Write-side front end for the 32x32 register file. Load-path (mem) and ALU-path
//   write-back requests are merged into the register file's single write port through
//   a small in-order circular queue. The head entry is presented combinationally on
//   wb_reg/wb_data with wb_enable = !empty and is popped on every posedge where
//   wb_enable is high; the register file samples on the following negedge.
//   Decode gets a combinational pending-write query on its two read indices.
//
//   Optional feature macro: REG_WB_FORWARD_EN
//     defined   : adds fwd_data_j/fwd_data_k carrying the data of the newest queued
//                 entry that targets the queried register (0 when none or index 0).
//     undefined : no forwarding ports; decode stalls while pending_* is high.

module reg_writeback_queue #(
   parameter int REGISTER_INDEX_SIZE = 5,
   parameter int DATA_SIZE           = 32,
   parameter int DEPTH               = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           mem_valid,
   input  logic [REGISTER_INDEX_SIZE-1:0] mem_reg,
   input  logic [DATA_SIZE-1:0]           mem_data,
   output logic                           mem_ready,
   input  logic                           alu_valid,
   input  logic [REGISTER_INDEX_SIZE-1:0] alu_reg,
   input  logic [DATA_SIZE-1:0]           alu_data,
   output logic                           alu_ready,
   output logic [REGISTER_INDEX_SIZE-1:0] wb_reg,
   output logic [DATA_SIZE-1:0]           wb_data,
   output logic                           wb_enable,
   input  logic [REGISTER_INDEX_SIZE-1:0] query_j,
   input  logic [REGISTER_INDEX_SIZE-1:0] query_k,
   output logic                           pending_j,
   output logic                           pending_k,
   output logic                           empty
`ifdef REG_WB_FORWARD_EN
   ,output logic [DATA_SIZE-1:0]          fwd_data_j
   ,output logic [DATA_SIZE-1:0]          fwd_data_k
`endif
);

   // Pointer and occupancy widths; the count needs one extra value to express "full".
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [CW-1:0]                  FULL_C   = CW'(DEPTH);
   localparam logic [CW-1:0]                  ALMOST_C = CW'(DEPTH - 2);
   localparam logic [CW-1:0]                  CNT_ZERO = {CW{1'b0}};
   localparam logic [PW-1:0]                  PTR_ZERO = {PW{1'b0}};
   localparam logic [REGISTER_INDEX_SIZE-1:0] REG_ZERO = {REGISTER_INDEX_SIZE{1'b0}};
   localparam logic [DATA_SIZE-1:0]           DAT_ZERO = {DATA_SIZE{1'b0}};

   // Queue storage and bookkeeping.
   logic [REGISTER_INDEX_SIZE-1:0] reg_mem_r  [DEPTH];
   logic [DATA_SIZE-1:0]           data_mem_r [DEPTH];
   logic [PW-1:0]                  head_r;
   logic [PW-1:0]                  tail_r;
   logic [CW-1:0]                  count_r;

   // Per-cycle control.
   logic                           mem_push_s;
   logic                           alu_push_s;
   logic                           pop_s;
   logic [PW-1:0]                  alu_slot_s;
   logic [PW-1:0]                  tail_next_s;
   logic [PW-1:0]                  head_next_s;
   logic [CW-1:0]                  count_next_s;

   // Hazard search results.
   logic                           hit_j_s;
   logic                           hit_k_s;
`ifdef REG_WB_FORWARD_EN
   logic [DATA_SIZE-1:0]           fwd_j_s;
   logic [DATA_SIZE-1:0]           fwd_k_s;
`endif

   // Readiness from the registered count only: a pop this cycle never frees space
   // early, and alu only gets a slot when a simultaneous mem request leaves room.
   always_comb begin
      mem_ready = (count_r < FULL_C);
      if (mem_valid) begin
         alu_ready = (count_r <= ALMOST_C);
      end else begin
         alu_ready = (count_r < FULL_C);
      end
   end

   // Accept/push/pop decisions; index-0 requests are accepted but never stored.
   always_comb begin
      mem_push_s   = mem_valid && mem_ready && (mem_reg != REG_ZERO);
      alu_push_s   = alu_valid && alu_ready && (alu_reg != REG_ZERO);
      pop_s        = (count_r != CNT_ZERO);
      alu_slot_s   = tail_r + PW'(mem_push_s);
      tail_next_s  = tail_r + PW'(mem_push_s) + PW'(alu_push_s);
      head_next_s  = head_r + PW'(pop_s);
      count_next_s = count_r + CW'(mem_push_s) + CW'(alu_push_s) - CW'(pop_s);
   end

   // Pointer and occupancy registers; reset discards every in-flight entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_r  <= PTR_ZERO;
         tail_r  <= PTR_ZERO;
         count_r <= CNT_ZERO;
      end else begin
         head_r  <= head_next_s;
         tail_r  <= tail_next_s;
         count_r <= count_next_s;
      end
   end

   // Entry storage; the mem entry is older so it takes the tail slot before alu.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            reg_mem_r[i]  <= REG_ZERO;
            data_mem_r[i] <= DAT_ZERO;
         end
      end else begin
         if (mem_push_s) begin
            reg_mem_r[tail_r]  <= mem_reg;
            data_mem_r[tail_r] <= mem_data;
         end
         if (alu_push_s) begin
            reg_mem_r[alu_slot_s]  <= alu_reg;
            data_mem_r[alu_slot_s] <= alu_data;
         end
      end
   end

   // Write-port drive: the head entry is shown straight from storage so it is
   // stable for the whole cycle and the register file can sample it at the negedge.
   always_comb begin
      empty     = (count_r == CNT_ZERO);
      wb_enable = !empty;
      wb_reg    = reg_mem_r[head_r];
      wb_data   = data_mem_r[head_r];
   end

`ifdef REG_WB_FORWARD_EN
   // Hazard search from oldest to newest so the last match wins the forward data.
   always_comb begin
      hit_j_s = 1'b0;
      hit_k_s = 1'b0;
      fwd_j_s = DAT_ZERO;
      fwd_k_s = DAT_ZERO;
      for (int k = 0; k < DEPTH; k++) begin
         if ((CW'(k) < count_r) && (reg_mem_r[head_r + PW'(k)] == query_j)) begin
            hit_j_s = 1'b1;
            fwd_j_s = data_mem_r[head_r + PW'(k)];
         end else begin
            hit_j_s = hit_j_s;
         end
         if ((CW'(k) < count_r) && (reg_mem_r[head_r + PW'(k)] == query_k)) begin
            hit_k_s = 1'b1;
            fwd_k_s = data_mem_r[head_r + PW'(k)];
         end else begin
            hit_k_s = hit_k_s;
         end
      end
   end

   // Forward outputs; register 0 never has a pending value.
   always_comb begin
      if (query_j != REG_ZERO) begin
         fwd_data_j = fwd_j_s;
      end else begin
         fwd_data_j = DAT_ZERO;
      end
      if (query_k != REG_ZERO) begin
         fwd_data_k = fwd_k_s;
      end else begin
         fwd_data_k = DAT_ZERO;
      end
   end
`else
   // Hazard search over the valid window (head included, it is still being written).
   always_comb begin
      hit_j_s = 1'b0;
      hit_k_s = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if ((CW'(k) < count_r) && (reg_mem_r[head_r + PW'(k)] == query_j)) begin
            hit_j_s = 1'b1;
         end else begin
            hit_j_s = hit_j_s;
         end
         if ((CW'(k) < count_r) && (reg_mem_r[head_r + PW'(k)] == query_k)) begin
            hit_k_s = 1'b1;
         end else begin
            hit_k_s = hit_k_s;
         end
      end
   end
`endif

   // Pending flags; register 0 is hard-wired and can never be a hazard.
   always_comb begin
      if (query_j != REG_ZERO) begin
         pending_j = hit_j_s;
      end else begin
         pending_j = 1'b0;
      end
      if (query_k != REG_ZERO) begin
         pending_k = hit_k_s;
      end else begin
         pending_k = 1'b0;
      end
   end

   reg_writeback_queue_checker #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_checker (
      .clk       (clk),
      .rst       (rst),
      .count     (count_r),
      .mem_ready (mem_ready),
      .alu_ready (alu_ready),
      .wb_enable (wb_enable),
      .empty     (empty)
   );

endmodule

// reg_writeback_queue_checker
//   Structural invariants of the write-back queue, kept apart from the datapath.
module reg_writeback_queue_checker #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input logic          clk,
   input logic          rst,
   input logic [CW-1:0] count,
   input logic          mem_ready,
   input logic          alu_ready,
   input logic          wb_enable,
   input logic          empty
);

   // Occupancy never exceeds the storage.
   a_count_bound: assert property (@(posedge clk) disable iff (rst)
      count <= CW'(DEPTH));

   // A full queue refuses both requesters.
   a_full_stall: assert property (@(posedge clk) disable iff (rst)
      (count == CW'(DEPTH)) |-> (!mem_ready && !alu_ready));

   // The write port is active exactly when something is queued.
   a_drain: assert property (@(posedge clk) disable iff (rst)
      wb_enable == !empty);

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: directed table, randomized traffic
// against a queue-based reference model, and a reset-mid-drain sequence.
// A stand-in register file samples the write port on each negedge.
module tb_reg_writeback_queue;

   localparam int RW    = 5;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_valid, alu_valid;
   logic [RW-1:0] mem_reg, alu_reg, query_j, query_k;
   logic [DW-1:0] mem_data, alu_data;
   logic          mem_ready, alu_ready, wb_enable, pending_j, pending_k, empty;
   logic [RW-1:0] wb_reg;
   logic [DW-1:0] wb_data;
`ifdef REG_WB_FORWARD_EN
   logic [DW-1:0] fwd_data_j, fwd_data_k;
`endif

   reg_writeback_queue #(.REGISTER_INDEX_SIZE(RW), .DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
      .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data), .alu_ready(alu_ready),
      .wb_reg(wb_reg), .wb_data(wb_data), .wb_enable(wb_enable),
      .query_j(query_j), .query_k(query_k), .pending_j(pending_j), .pending_k(pending_k),
      .empty(empty)
`ifdef REG_WB_FORWARD_EN
      , .fwd_data_j(fwd_data_j), .fwd_data_k(fwd_data_k)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [RW-1:0] r;
      logic [DW-1:0] d;
   } ent_t;

   typedef struct {
      logic mv; logic [RW-1:0] mr; logic [DW-1:0] md;
      logic av; logic [RW-1:0] ar; logic [DW-1:0] ad;
      logic [RW-1:0] qj; logic [RW-1:0] qk;
      logic e_mr; logic e_ar; logic e_pj; logic e_pk; logic e_empty; logic e_wben;
      logic [RW-1:0] e_reg; logic [DW-1:0] e_data; logic [DW-1:0] e_fj;
   } vec_t;

   ent_t          q[$];
   logic [DW-1:0] gold_rf [32];
   logic [DW-1:0] rf      [32];
   vec_t          tbl     [17];
   int            checks = 0;
   int            errors = 0;

   // Register-file stand-in: writes land on the negedge after presentation.
   always @(negedge clk) begin
      if (wb_enable) rf[wb_reg] <= wb_data;
   end

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic m_pend(input logic [RW-1:0] qx);
      logic hit = 1'b0;
      if (qx == 5'd0) return 1'b0;
      foreach (q[i]) if (q[i].r == qx) hit = 1'b1;
      return hit;
   endfunction

   function automatic logic [DW-1:0] m_fwd(input logic [RW-1:0] qx);
      logic [DW-1:0] v = 32'd0;
      if (qx == 5'd0) return 32'd0;
      foreach (q[i]) if (q[i].r == qx) v = q[i].d;
      return v;
   endfunction

   // Compare all DUT outputs against the reference queue.
   task automatic model_check();
      int n = q.size();
      check("empty", {31'd0, empty}, {31'd0, n == 0});
      check("wb_enable", {31'd0, wb_enable}, {31'd0, n != 0});
      if (n != 0) begin
         check("wb_reg", {27'd0, wb_reg}, {27'd0, q[0].r});
         check("wb_data", wb_data, q[0].d);
      end
      check("mem_ready", {31'd0, mem_ready}, {31'd0, n < DEPTH});
      check("alu_ready", {31'd0, alu_ready},
            {31'd0, mem_valid ? (n <= DEPTH - 2) : (n < DEPTH)});
      check("pending_j", {31'd0, pending_j}, {31'd0, m_pend(query_j)});
      check("pending_k", {31'd0, pending_k}, {31'd0, m_pend(query_k)});
`ifdef REG_WB_FORWARD_EN
      check("fwd_data_j", fwd_data_j, m_fwd(query_j));
      check("fwd_data_k", fwd_data_k, m_fwd(query_k));
`endif
   endtask

   // Advance the reference by one posedge: pop the head, then push mem, then alu.
   task automatic model_step(input logic mv, input logic [RW-1:0] mr, input logic [DW-1:0] md,
                             input logic av, input logic [RW-1:0] ar, input logic [DW-1:0] ad,
                             output logic macc, output logic aacc);
      int   n = q.size();
      ent_t e;
      macc = mv && (n < DEPTH);
      aacc = av && (mv ? (n <= DEPTH - 2) : (n < DEPTH));
      if (n != 0) begin
         e = q.pop_front();
         gold_rf[e.r] = e.d;
      end
      if (macc && mr != 5'd0) q.push_back('{r: mr, d: md});
      if (aacc && ar != 5'd0) q.push_back('{r: ar, d: ad});
   endtask

   // One clock cycle: drive at posedge+1, check at posedge+4, then step the model.
   task automatic cycle(input logic mv, input logic [RW-1:0] mr, input logic [DW-1:0] md,
                        input logic av, input logic [RW-1:0] ar, input logic [DW-1:0] ad,
                        input logic [RW-1:0] qj, input logic [RW-1:0] qk, input int ti,
                        output logic macc, output logic aacc);
      mem_valid = mv; mem_reg = mr; mem_data = md;
      alu_valid = av; alu_reg = ar; alu_data = ad;
      query_j = qj; query_k = qk;
      #3;
      if (ti >= 0) begin
         check($sformatf("tbl%0d.mem_ready", ti), {31'd0, mem_ready}, {31'd0, tbl[ti].e_mr});
         check($sformatf("tbl%0d.alu_ready", ti), {31'd0, alu_ready}, {31'd0, tbl[ti].e_ar});
         check($sformatf("tbl%0d.pending_j", ti), {31'd0, pending_j}, {31'd0, tbl[ti].e_pj});
         check($sformatf("tbl%0d.pending_k", ti), {31'd0, pending_k}, {31'd0, tbl[ti].e_pk});
         check($sformatf("tbl%0d.empty", ti), {31'd0, empty}, {31'd0, tbl[ti].e_empty});
         check($sformatf("tbl%0d.wb_enable", ti), {31'd0, wb_enable}, {31'd0, tbl[ti].e_wben});
         if (tbl[ti].e_wben) begin
            check($sformatf("tbl%0d.wb_reg", ti), {27'd0, wb_reg}, {27'd0, tbl[ti].e_reg});
            check($sformatf("tbl%0d.wb_data", ti), wb_data, tbl[ti].e_data);
         end
`ifdef REG_WB_FORWARD_EN
         check($sformatf("tbl%0d.fwd_data_j", ti), fwd_data_j, tbl[ti].e_fj);
`endif
      end
      model_check();
      @(posedge clk);
      model_step(mv, mr, md, av, ar, ad, macc, aacc);
      #1;
   endtask

   initial begin
      logic          macc, aacc;
      logic          hm, ha;
      logic [RW-1:0] rm, ra;
      logic [DW-1:0] dm, da;

      //           mv    mr     md             av    ar     ad             qj     qk    mr   ar   pj   pk   emp  wben reg    data           fj
      tbl[0]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'h12345678, 5'd5, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,5'd0, 32'h0,        32'h0};
      tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,5'd5, 32'h12345678, 32'h12345678};
      tbl[2]  = '{1'b1, 5'd3, 32'hAAAA,     1'b1, 5'd3, 32'hBBBB,     5'd3, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,5'd0, 32'h0,        32'h0};
      tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd3, 5'd0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,5'd3, 32'hAAAA,     32'hBBBB};
      tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd3, 5'd0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,5'd3, 32'hBBBB,     32'hBBBB};
      tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,5'd0, 32'h0,        32'h0};
      tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,5'd0, 32'h0,        32'h0};
      tbl[7]  = '{1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,       5'd1, 5'd2, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,5'd0, 32'h0,        32'h0};
      tbl[8]  = '{1'b1, 5'd4, 32'h44,       1'b1, 5'd6, 32'h66,       5'd1, 5'd6, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,5'd1, 32'h11,       32'h11};
      tbl[9]  = '{1'b1, 5'd8, 32'h88,       1'b1, 5'd9, 32'h99,       5'd2, 5'd9, 1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,5'd2, 32'h22,       32'h22};
      tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h99,       5'd8, 5'd9, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,5'd4, 32'h44,       32'h88};
      tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd6, 5'd9, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,5'd6, 32'h66,       32'h66};
      tbl[12] = '{1'b1, 5'd7, 32'h1,        1'b1, 5'd7, 32'h2,        5'd7, 5'd8, 1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,5'd8, 32'h88,       32'h0};
      tbl[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd7, 5'd9, 1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,5'd9, 32'h99,       32'h2};
      tbl[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,5'd7, 32'h1,        32'h2};
      tbl[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,5'd7, 32'h2,        32'h2};
      tbl[16] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        5'd7, 5'd0, 1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,5'd0, 32'h0,        32'h0};

      for (int r = 0; r < 32; r++) begin
         gold_rf[r] = 32'd0;
         rf[r]      = 32'd0;
      end

      // Reset state.
      rst = 1'b1;
      mem_valid = 1'b0; mem_reg = 5'd0; mem_data = 32'd0;
      alu_valid = 1'b0; alu_reg = 5'd0; alu_data = 32'd0;
      query_j = 5'd5; query_k = 5'd0;
      #2;
      check("rst.wb_enable", {31'd0, wb_enable}, 32'd0);
      check("rst.empty", {31'd0, empty}, 32'd1);
      check("rst.wb_reg", {27'd0, wb_reg}, 32'd0);
      check("rst.wb_data", wb_data, 32'd0);
      check("rst.pending_j", {31'd0, pending_j}, 32'd0);
      check("rst.mem_ready", {31'd0, mem_ready}, 32'd1);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // Directed table.
      for (int i = 0; i < 17; i++) begin
         cycle(tbl[i].mv, tbl[i].mr, tbl[i].md, tbl[i].av, tbl[i].ar, tbl[i].ad,
               tbl[i].qj, tbl[i].qk, i, macc, aacc);
      end
      check("rf.r5", rf[5], 32'h12345678);
      check("rf.r3", rf[3], 32'hBBBB);
      check("rf.r7", rf[7], 32'h2);
      check("rf.r0", rf[0], 32'h0);

      // Randomized traffic; a refused requester holds its request stable.
      hm = 1'b0; ha = 1'b0;
      rm = 5'd0; ra = 5'd0; dm = 32'd0; da = 32'd0;
      for (int i = 0; i < 400; i++) begin
         if (!hm) begin
            hm = ($urandom_range(0, 1) == 1);
            rm = 5'($urandom_range(0, 7));
            dm = $urandom;
         end
         if (!ha) begin
            ha = ($urandom_range(0, 1) == 1);
            ra = 5'($urandom_range(0, 7));
            da = $urandom;
         end
         cycle(hm, rm, dm, ha, ra, da, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               -1, macc, aacc);
         if (macc) hm = 1'b0;
         if (aacc) ha = 1'b0;
      end

      // Drain, bounded.
      for (int i = 0; i < 8 && q.size() != 0; i++)
         cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2, -1, macc, aacc);
      check("drain.empty", {31'd0, empty}, 32'd1);

      // Reset mid-drain with three entries queued.
      cycle(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hA1, 5'd11, 5'd10, -1, macc, aacc);
      cycle(1'b1, 5'd12, 32'hA2, 1'b1, 5'd13, 32'hA3, 5'd12, 5'd13, -1, macc, aacc);
      mem_valid = 1'b0; alu_valid = 1'b0; query_j = 5'd12; query_k = 5'd13;
      check("pre_rst.count3", {31'd0, (q.size() == 3) && wb_enable}, 32'd1);
      rst = 1'b1;
      #1;
      q.delete();
      check("mid_rst.wb_enable", {31'd0, wb_enable}, 32'd0);
      check("mid_rst.empty", {31'd0, empty}, 32'd1);
      check("mid_rst.pending_j", {31'd0, pending_j}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd11, 5'd12, -1, macc, aacc);
      cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 32'hC0FFEE, 5'd20, 5'd0, -1, macc, aacc);
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd20, 5'd11, -1, macc, aacc);

      // Register-file contents must match acceptance-order replay.
      for (int r = 0; r < 32; r++)
         check($sformatf("rf.r%0d", r), rf[r], gold_rf[r]);
      check("rf.r11_no_stale", rf[11], 32'd0);
      check("rf.r20", rf[20], 32'hC0FFEE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
